// File: rtl/delay_timer_mc.sv
// Multi-channel delay timer: each channel counts N ticks of CLK_HZ/TICK_HZ clocks,
// with one-shot or auto-reload behaviour, abort, busy and a registered expiry pulse.
module delay_timer_mc #(
    parameter int NCH     = 2,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*CNT_W-1:0] delay_time,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH-1:0]       periodic,
    output logic [NCH-1:0]       delay_done,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       expired
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 1) begin : g_bad_param
        $error("delay_timer_mc: CLK_HZ must be a non-zero multiple of TICK_HZ");
    end

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t           state_reg, state_next;
        logic [CNT_W-1:0] stop_reg, stop_next;
        logic [CNT_W-1:0] remaining_reg, remaining_next;
        logic [PRE_W-1:0] pre_reg, pre_next;
        logic             expired_reg, expired_next;
        logic [CNT_W-1:0] dt;
        logic             tick;
        logic             expiry;
        logic             busy_ch;
        logic             done_ch;

        assign dt   = delay_time[gi*CNT_W +: CNT_W];
        assign tick = (pre_reg == PRE_W'(DIV - 1));
        // remaining==0 in HOLD only happens on the first cycle after a start/reload with N=0
        assign expiry = (state_reg == S_HOLD) &&
                        ((remaining_reg == '0) || (tick && remaining_reg == CNT_W'(1)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg     <= S_IDLE;
                stop_reg      <= '0;
                remaining_reg <= '0;
                pre_reg       <= '0;
                expired_reg   <= 1'b0;
            end else begin
                state_reg     <= state_next;
                stop_reg      <= stop_next;
                remaining_reg <= remaining_next;
                pre_reg       <= pre_next;
                expired_reg   <= expired_next;
            end
        end

        always_comb begin
            state_next     = state_reg;
            stop_next      = stop_reg;
            remaining_next = remaining_reg;
            pre_next       = pre_reg;
            if (abort[gi]) begin
                state_next     = S_IDLE;
                remaining_next = '0;
                pre_next       = '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        stop_next = dt;
                        if (start[gi]) begin
                            state_next     = S_HOLD;
                            remaining_next = dt;
                            pre_next       = '0;
                        end
                    end
                    S_HOLD: begin
                        if (expiry) begin
                            // reload from the value latched at start, not the live input
                            if (start[gi] && periodic[gi]) begin
                                remaining_next = stop_reg;
                                pre_next       = '0;
                            end else begin
                                state_next = start[gi] ? S_DONE : S_IDLE;
                            end
                        end else begin
                            pre_next = tick ? '0 : pre_reg + PRE_W'(1);
                            if (tick) remaining_next = remaining_reg - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (!start[gi]) state_next = S_IDLE;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end

        always_comb begin
            expired_next = expiry && !abort[gi];
            busy_ch      = (state_reg == S_HOLD);
            done_ch      = (state_reg == S_IDLE) && !start[gi];
        end

        assign expired[gi]    = expired_reg;
        assign busy[gi]       = busy_ch;
        assign delay_done[gi] = done_ch;
    end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Bench for delay_timer_mc: a DIV=10 and a DIV=1 instance share stimulus and are
// compared every cycle against a deadline-based reference model.
module tb_delay_timer_mc;
    localparam int NCH   = 2;
    localparam int CNT_W = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*CNT_W-1:0] delay_time;
    logic [NCH-1:0]       start, abort, periodic;
    logic [NCH-1:0]       done_a, busy_a, exp_a;
    logic [NCH-1:0]       done_b, busy_b, exp_b;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint t        = 0;

    // model state per instance/channel: 0 idle, 1 counting, 2 done
    int     m_state[2][NCH];
    longint m_deadline[2][NCH];
    int     m_stop[2][NCH];
    bit     m_exp[2][NCH];
    int     divs[2] = '{10, 1};

    delay_timer_mc #(.NCH(NCH), .CLK_HZ(1000), .TICK_HZ(100), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .delay_time(delay_time), .start(start), .abort(abort),
        .periodic(periodic), .delay_done(done_a), .busy(busy_a), .expired(exp_a));

    delay_timer_mc #(.NCH(NCH), .CLK_HZ(1000), .TICK_HZ(1000), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .delay_time(delay_time), .start(start), .abort(abort),
        .periodic(periodic), .delay_done(done_b), .busy(busy_b), .expired(exp_b));

    always #5 clk = ~clk;

    function automatic longint dur(int n, int div);
        return (n == 0) ? 1 : longint'(n) * div;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                m_state[d][c] = 0;
                m_exp[d][c]   = 0;
            end
    endtask

    task automatic model_edge();
        t++;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                int n;
                n = int'(delay_time[c*CNT_W +: CNT_W]);
                m_exp[d][c] = 0;
                if (rst || abort[c]) begin
                    m_state[d][c] = 0;
                end else if (m_state[d][c] == 0) begin
                    m_stop[d][c] = n;
                    if (start[c]) begin
                        m_state[d][c]    = 1;
                        m_deadline[d][c] = t + dur(n, divs[d]);
                    end
                end else if (m_state[d][c] == 1) begin
                    if (t == m_deadline[d][c]) begin
                        m_exp[d][c] = 1;
                        if (start[c] && periodic[c])
                            m_deadline[d][c] = t + dur(m_stop[d][c], divs[d]);
                        else
                            m_state[d][c] = start[c] ? 2 : 0;
                    end
                end else if (!start[c]) begin
                    m_state[d][c] = 0;
                end
            end
    endtask

    task automatic check(string tag, logic [NCH-1:0] obs, logic [NCH-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, expv);
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [NCH-1:0] eb, ed, ee;
            for (int c = 0; c < NCH; c++) begin
                eb[c] = (m_state[d][c] == 1);
                ed[c] = (m_state[d][c] == 0) && !start[c];
                ee[c] = m_exp[d][c];
            end
            check(d == 0 ? "busy_div10" : "busy_div1", d == 0 ? busy_a : busy_b, eb);
            check(d == 0 ? "done_div10" : "done_div1", d == 0 ? done_a : done_b, ed);
            check(d == 0 ? "expired_div10" : "expired_div1", d == 0 ? exp_a : exp_b, ee);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic set_n(int c, int n);
        delay_time[c*CNT_W +: CNT_W] = CNT_W'(n);
    endtask

    initial begin
        rst        = 1'b1;
        delay_time = '0;
        start      = 2'b01;
        abort      = '0;
        periodic   = '0;
        model_reset();
        #1;
        check_all();
        run(2);
        @(negedge clk);
        rst   = 1'b0;
        start = '0;
        run(2);

        // one-shot N=3 on ch0, held start, then release
        set_n(0, 3);
        start[0] = 1'b1;
        run(40);
        start[0] = 1'b0;
        run(5);

        // periodic N=2 on ch1, start dropped mid-period
        set_n(1, 2);
        periodic[1] = 1'b1;
        start[1]    = 1'b1;
        run(45);
        start[1] = 1'b0;
        run(25);
        periodic[1] = 1'b0;

        // abort pulse mid-count with start still high
        set_n(0, 5);
        start[0] = 1'b1;
        run(17);
        abort[0] = 1'b1;
        run(1);
        abort[0] = 1'b0;
        run(60);
        start[0] = 1'b0;
        run(3);

        // N=0 and N=1 started on the same edge, delay_time changed mid-count
        set_n(0, 0);
        set_n(1, 1);
        start = 2'b11;
        run(4);
        set_n(0, 9);
        set_n(1, 9);
        run(10);
        start = 2'b00;
        run(3);

        // asynchronous reset in the middle of an N=4 count
        set_n(0, 4);
        start[0] = 1'b1;
        run(12);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        run(2);
        rst = 1'b0;
        run(50);
        start[0] = 1'b0;
        run(3);

        // periodic N=7 on both channels simultaneously
        set_n(0, 7);
        set_n(1, 7);
        periodic = 2'b11;
        start    = 2'b11;
        run(160);
        start = 2'b00;
        run(80);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(29) == 0) start[c] = ~start[c];
                abort[c]    = ($urandom_range(59) == 0);
                periodic[c] = 1'($urandom_range(1));
                set_n(c, int'($urandom_range(6)));
            end
            run(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
